// File: rtl/time_set_ctrl.sv
// Front-panel time-set controller: captures the running time, lets the user
// edit hour/minute/second with wrap-around and auto-repeat, then strobes Timeset.
module time_set_ctrl #(
  parameter int TIMEOUT    = 1000,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic       inc_i,
  input  logic       cancel_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic       Timeset,
  output logic [4:0] Hourset,
  output logic [5:0] Minset,
  output logic [5:0] Secset,
  output logic [1:0] edit_o
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [RW-1:0] DLY_CNT  = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] PER_CNT  = RW'(REPEAT_PER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EDIT_H = 3'd1,
    S_EDIT_M = 3'd2,
    S_EDIT_S = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t state, state_nx;

  logic mode_q, inc_q, cancel_q;
  logic mode_edge, inc_edge, cancel_edge;

  logic [4:0] hour_q, hour_nx;
  logic [5:0] min_q, min_nx;
  logic [5:0] sec_q, sec_nx;

  logic [RW-1:0] hold_cnt, hold_nx, hold_inc, rep_target;
  logic          rep_on, rep_on_nx;
  logic          rep_fire;
  logic          in_edit;
  logic          activity;

  logic [TW-1:0] tmo_cnt, tmo_nx, tmo_inc;

  assign mode_edge   = mode_i & ~mode_q;
  assign inc_edge    = inc_i & ~inc_q;
  assign cancel_edge = cancel_i & ~cancel_q;

  assign in_edit = (state == S_EDIT_H) || (state == S_EDIT_M) || (state == S_EDIT_S);

  // Hold counter runs in two phases: first up to the initial delay, then
  // restarting every repeat period once rep_on is set.
  assign hold_inc   = hold_cnt + RW'(1);
  assign rep_target = rep_on ? PER_CNT : DLY_CNT;
  assign rep_fire   = in_edit & inc_i & ~inc_edge & (hold_inc == rep_target);

  assign activity = mode_edge | inc_edge | cancel_edge | rep_fire;
  assign tmo_inc  = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TW'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      cancel_q <= 1'b0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      hold_cnt <= '0;
      rep_on   <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nx;
      mode_q   <= mode_i;
      inc_q    <= inc_i;
      cancel_q <= cancel_i;
      hour_q   <= hour_nx;
      min_q    <= min_nx;
      sec_q    <= sec_nx;
      hold_cnt <= hold_nx;
      rep_on   <= rep_on_nx;
      tmo_cnt  <= tmo_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    hour_nx   = hour_q;
    min_nx    = min_q;
    sec_nx    = sec_q;
    hold_nx   = '0;
    rep_on_nx = 1'b0;
    tmo_nx    = '0;

    case (state)
      S_IDLE: begin
        if (mode_edge) begin
          // Out-of-range readings from the core are loaded as zero.
          hour_nx  = (cur_hour_i > 5'd23) ? 5'd0 : cur_hour_i;
          min_nx   = (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
          sec_nx   = (cur_sec_i > 6'd59) ? 6'd0 : cur_sec_i;
          state_nx = S_EDIT_H;
        end
      end

      S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
        if (cancel_edge) begin
          state_nx = S_IDLE;
        end else if (mode_edge) begin
          case (state)
            S_EDIT_H: state_nx = S_EDIT_M;
            S_EDIT_M: state_nx = S_EDIT_S;
            default:  state_nx = S_COMMIT;
          endcase
        end else begin
          if (inc_i && !inc_edge) begin
            hold_nx   = rep_fire ? '0 : hold_inc;
            rep_on_nx = rep_on | rep_fire;
          end

          if (inc_edge || rep_fire) begin
            case (state)
              S_EDIT_H: hour_nx = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
              S_EDIT_M: min_nx  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
              default:  sec_nx  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            endcase
          end

          if (!activity) begin
            tmo_nx = tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              state_nx = S_IDLE;
            end
          end
        end
      end

      S_COMMIT: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    edit_o = 2'd0;
    case (state)
      S_EDIT_H: edit_o = 2'd1;
      S_EDIT_M: edit_o = 2'd2;
      S_EDIT_S: edit_o = 2'd3;
      default:  edit_o = 2'd0;
    endcase
  end

  // Decoded from the state register so an asynchronous reset drops it at once.
  assign Timeset = (state == S_COMMIT);
  assign Hourset = hour_q;
  assign Minset  = min_q;
  assign Secset  = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: cycle model of the edit rules, commit scoreboard
// and directed button sequences with hand-computed expectations.
module tb_time_set_ctrl;

  localparam int TIMEOUT    = 1000;
  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_PER = 4;

  logic       clk;
  logic       reset_i;
  logic       mode_i, inc_i, cancel_i;
  logic [4:0] cur_hour_i;
  logic [5:0] cur_min_i, cur_sec_i;
  logic       Timeset;
  logic [4:0] Hourset;
  logic [5:0] Minset, Secset;
  logic [1:0] edit_o;

  time_set_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .mode_i    (mode_i),
    .inc_i     (inc_i),
    .cancel_i  (cancel_i),
    .cur_hour_i(cur_hour_i),
    .cur_min_i (cur_min_i),
    .cur_sec_i (cur_sec_i),
    .Timeset   (Timeset),
    .Hourset   (Hourset),
    .Minset    (Minset),
    .Secset    (Secset),
    .edit_o    (edit_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int commits  = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: field 0 idle, 1 hour, 2 minute, 3 second, 4 commit.
  int m_field, m_h, m_m, m_s, m_held, m_idle;
  bit m_pm, m_pi, m_pc;

  task automatic model_step();
    bit me, ie, ce, rep;
    me  = mode_i && !m_pm;
    ie  = inc_i && !m_pi;
    ce  = cancel_i && !m_pc;
    rep = 1'b0;
    if (m_field >= 1 && m_field <= 3) begin
      if (ce) begin
        m_field = 0;
      end else if (me) begin
        m_field = m_field + 1;
        m_idle  = 0;
        m_held  = 0;
      end else begin
        if (!inc_i || ie) begin
          m_held = 0;
        end else begin
          m_held = m_held + 1;
          rep = (m_held == REPEAT_DLY) ||
                (m_held > REPEAT_DLY && ((m_held - REPEAT_DLY) % REPEAT_PER) == 0);
        end
        if (ie || rep) begin
          if (m_field == 1) m_h = (m_h + 1) % 24;
          else if (m_field == 2) m_m = (m_m + 1) % 60;
          else m_s = (m_s + 1) % 60;
          m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
          if (m_idle >= TIMEOUT) m_field = 0;
        end
      end
    end else if (m_field == 4) begin
      m_field = 0;
    end else if (me) begin
      m_h     = (cur_hour_i > 23) ? 0 : int'(cur_hour_i);
      m_m     = (cur_min_i > 59) ? 0 : int'(cur_min_i);
      m_s     = (cur_sec_i > 59) ? 0 : int'(cur_sec_i);
      m_field = 1;
      m_idle  = 0;
      m_held  = 0;
    end
    m_pm = mode_i;
    m_pi = inc_i;
    m_pc = cancel_i;
  endtask

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_held = 0; m_idle = 0;
      m_pm = 0; m_pi = 0; m_pc = 0;
    end else begin
      model_step();
    end
  end

  // compare process and commit scoreboard
  always @(negedge clk) begin
    if (!reset_i) begin
      check("model_timeset", Timeset, (m_field == 4) ? 1 : 0);
      check("model_edit", edit_o, (m_field >= 1 && m_field <= 3) ? m_field : 0);
      check("model_hour", Hourset, m_h);
      check("model_min", Minset, m_m);
      check("model_sec", Secset, m_s);
      if (Timeset === 1'b1) begin
        commits++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual=%0d:%0d:%0d required=none at %0t",
                   Hourset, Minset, Secset, $time);
        end else begin
          check("commit_value", {Hourset, Minset, Secset}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    mode_i = 1'b1; tick(1); mode_i = 1'b0; tick(1);
  endtask

  task automatic press_inc();
    inc_i = 1'b1; tick(1); inc_i = 1'b0; tick(1);
  endtask

  task automatic press_cancel();
    cancel_i = 1'b1; tick(1); cancel_i = 1'b0; tick(1);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour_i = 5'(h); cur_min_i = 6'(m); cur_sec_i = 6'(s);
  endtask

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    mode_i = 1'b0; inc_i = 1'b0; cancel_i = 1'b0;
    set_cur(11, 59, 59);
    #1;
    check("reset_timeset", Timeset, 0);
    check("reset_edit", edit_o, 0);
    check("reset_fields", {Hourset, Minset, Secset}, 0);
    tick(2);
    reset_i = 1'b0;
    tick(1);

    // capture and commit without edits
    press_mode();
    check("cap_edit_h", edit_o, 1);
    check("cap_value", {Hourset, Minset, Secset}, hms(11, 59, 59));
    press_mode();
    check("cap_edit_m", edit_o, 2);
    press_mode();
    check("cap_edit_s", edit_o, 3);
    exp_q.push_back(hms(11, 59, 59));
    press_mode();
    check("cap_back_idle", edit_o, 0);

    // wrap of every field
    set_cur(23, 59, 59);
    press_mode(); press_inc();
    check("wrap_hour", Hourset, 0);
    press_mode(); press_inc();
    check("wrap_min", Minset, 0);
    press_mode(); press_inc();
    check("wrap_sec", Secset, 0);
    exp_q.push_back(hms(0, 0, 0));
    press_mode();

    // auto-repeat: 17 held samples -> edge + repeats at 8, 12, 16
    set_cur(5, 10, 0);
    press_mode(); press_mode();
    check("rep_start_min", Minset, 10);
    inc_i = 1'b1;
    tick(1 + REPEAT_DLY + 2 * REPEAT_PER);
    inc_i = 1'b0;
    tick(1);
    check("rep_min", Minset, 14);
    press_cancel();
    check("rep_cancel_idle", edit_o, 0);
    check("rep_cancel_keeps", Minset, 14);

    // cancel beats mode and inc
    set_cur(1, 2, 3);
    press_mode(); press_mode(); press_mode();
    cancel_i = 1'b1; mode_i = 1'b1; inc_i = 1'b1;
    tick(1);
    check("prio_cancel_idle", edit_o, 0);
    check("prio_cancel_sec", Secset, 3);
    cancel_i = 1'b0; mode_i = 1'b0; inc_i = 1'b0;
    tick(1);

    // mode beats inc
    set_cur(7, 8, 9);
    press_mode();
    mode_i = 1'b1; inc_i = 1'b1;
    tick(1);
    check("prio_mode_edit", edit_o, 2);
    check("prio_mode_hour", Hourset, 7);
    mode_i = 1'b0; inc_i = 1'b0;
    tick(1);
    press_cancel();

    // timeout: entry at edge E, idle at edge E+TIMEOUT
    set_cur(4, 5, 6);
    press_mode();
    tick(TIMEOUT - 2);
    check("tmo_before", edit_o, 1);
    tick(1);
    check("tmo_after", edit_o, 0);

    // inc at cycle TIMEOUT-5 extends the timeout
    press_mode();
    tick(TIMEOUT - 7);
    inc_i = 1'b1;
    tick(1);
    inc_i = 1'b0;
    tick(5);
    check("ext_still_edit", edit_o, 1);
    check("ext_hour", Hourset, 5);
    tick(TIMEOUT - 6);
    check("ext_before", edit_o, 1);
    tick(1);
    check("ext_after", edit_o, 0);

    // reset during COMMIT
    set_cur(9, 30, 45);
    press_mode(); press_mode(); press_mode();
    exp_q.push_back(hms(9, 30, 45));
    mode_i = 1'b1;
    tick(1);
    check("commit_high", Timeset, 1);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_timeset", Timeset, 0);
    check("rst_edit", edit_o, 0);
    check("rst_fields", {Hourset, Minset, Secset}, 0);

    // a button high when reset releases counts as an edge
    set_cur(12, 34, 56);
    tick(1);
    reset_i = 1'b0;
    tick(1);
    check("post_rst_edit", edit_o, 1);
    check("post_rst_value", {Hourset, Minset, Secset}, hms(12, 34, 56));
    mode_i = 1'b0;
    tick(1);
    press_cancel();

    // out-of-range capture clamps to zero
    set_cur(25, 61, 63);
    press_mode();
    check("clamp_value", {Hourset, Minset, Secset}, 0);
    check("clamp_edit", edit_o, 1);
    press_cancel();

    tick(2);
    check("commit_count", commits, 3);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
